// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module  : prog_loader_pkg
// Purpose : Shared definitions for the program loader: FSM state encoding,
//           checksum seed and default geometry. Imported by the loader RTL
//           and by its testbench.
// Config  : PROG_LOADER_CHECKSUM_EN (see prog_loader.sv) uses ST_CHK and
//           c_CSUM_SEED; the encodings are identical in both builds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam int         c_DEPTH_DEFAULT     = 32;
    localparam logic [7:0] c_BASE_ADDR_DEFAULT = 8'h00;
    localparam logic [7:0] c_CSUM_SEED         = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // States in which the loader consumes host bytes.
    function automatic logic takes_input(input state_t s);
        return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module  : prog_loader_if
// Purpose : Host-stream, RAM-write and status bundle of the program loader.
//   start/in_data/in_valid : host -> loader (arm, byte stream)
//   in_ready               : loader -> host (byte accepted this cycle)
//   mem_we/mem_addr/mem_data : loader -> instruction RAM write port
//   cpu_hold/load_done/load_err/words_loaded : loader status
//   modport master : host / RAM side ; modport slave : loader side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_loader_if;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [7:0] words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data,
        input  cpu_hold, load_done, load_err, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data,
        output cpu_hold, load_done, load_err, words_loaded
    );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module  : prog_loader
// Purpose : Frames a host byte stream (length byte N, then N data bytes) into
//           a program image, writes it into the instruction RAM starting at
//           BASE_ADDR, and holds the core off the RAM until the image is in.
// Ports   : clk, rst (synchronous, active high)
//           bus (prog_loader_if.slave): start, in_data, in_valid, in_ready,
//           mem_we, mem_addr, mem_data, cpu_hold, load_done, load_err,
//           words_loaded
// Params  : DEPTH     - max image length in bytes
//           BASE_ADDR - RAM address of the first image byte
// Config  : `define PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
//           (state ST_CHK); mismatch ends in ST_ERR.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DEPTH     = c_DEPTH_DEFAULT,
    parameter logic [7:0] BASE_ADDR = c_BASE_ADDR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);

    localparam logic [8:0] c_DEPTH9 = 9'(DEPTH);

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic       r_in_ready;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_data;
    logic       r_cpu_hold;
    logic       r_load_done;
    logic       r_load_err;
    logic [7:0] r_words_loaded;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_acc;
`endif

    logic       w_xfer;
    logic [7:0] w_idx_inc;
    logic       w_last;
    logic       w_len_zero;
    logic       w_len_over;

    // r_in_ready mirrors the current state, so it doubles as the state decode.
    assign w_xfer     = bus.in_valid & r_in_ready;
    assign w_idx_inc  = r_idx + 8'd1;
    assign w_last     = (w_idx_inc == r_len);
    assign w_len_zero = (bus.in_data == 8'h00);
    assign w_len_over = ({1'b0, bus.in_data} > c_DEPTH9);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_HDR;
            end
            ST_HDR: begin
                if (w_xfer) begin
                    if (w_len_over) begin
                        w_next = ST_ERR;
                    end else if (w_len_zero) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_next = ST_CHK;
`else
                        w_next = ST_DONE;
`endif
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_next = ST_CHK;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (w_xfer) begin
                    w_next = (r_acc == bus.in_data) ? ST_DONE : ST_ERR;
                end
`else
                w_next = ST_IDLE;   // unreachable without the checksum stage
`endif
            end
            ST_DONE, ST_ERR: begin
                if (bus.start) w_next = ST_HDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath. Status outputs are derived from the
    // next state so they change in the same cycle the state does; this makes
    // the final RAM write and cpu_hold release coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len          <= 8'h00;
            r_idx          <= 8'h00;
            r_in_ready     <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= BASE_ADDR;
            r_mem_data     <= 8'h00;
            r_cpu_hold     <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
            r_words_loaded <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_acc          <= c_CSUM_SEED;
`endif
        end else begin
            r_in_ready  <= takes_input(w_next);
            r_cpu_hold  <= (w_next != ST_DONE);
            r_load_done <= (w_next == ST_DONE);
            r_load_err  <= (w_next == ST_ERR);
            r_mem_we    <= 1'b0;

            // Arming a new load clears the byte count of the previous one.
            if ((w_next == ST_HDR) && (r_state != ST_HDR)) begin
                r_words_loaded <= 8'h00;
            end

            if ((r_state == ST_HDR) && w_xfer) begin
                r_len <= bus.in_data;
                r_idx <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_acc <= c_CSUM_SEED;
`endif
            end

            if ((r_state == ST_DATA) && w_xfer) begin
                r_mem_we       <= 1'b1;
                r_mem_addr     <= BASE_ADDR + r_idx;   // wraps mod 256
                r_mem_data     <= bus.in_data;
                r_words_loaded <= w_idx_inc;
                r_idx          <= w_idx_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_acc          <= r_acc ^ bus.in_data;
`endif
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_data     = r_mem_data;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.load_done    = r_load_done;
    assign bus.load_err     = r_load_err;
    assign bus.words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module  : tb_prog_loader
// Purpose : Self-checking bench for prog_loader: table of framed images with
//           expected status/write log, plus hand sequences for reset, ignored
//           input, mid-load reset, start during DATA and a full-depth image.
//           Follows PROG_LOADER_CHECKSUM_EN when it is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;
    import prog_loader_pkg::*;

    logic clk;
    logic rst;

    prog_loader_if bus ();

    prog_loader #(
        .DEPTH     (32),
        .BASE_ADDR (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write log captured away from the active edge.
    int         cyc = 0;
    logic [7:0] q_addr [$];
    logic [7:0] q_data [$];
    int         q_cyc  [$];
    logic       q_hold [$];
    logic       q_done [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_we === 1'b1) begin
            q_addr.push_back(bus.mem_addr);
            q_data.push_back(bus.mem_data);
            q_cyc.push_back(cyc);
            q_hold.push_back(bus.cpu_hold);
            q_done.push_back(bus.load_done);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        q_hold.delete();
        q_done.delete();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        logic taken;
        taken       = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = bus.in_ready;
            tick(1);
        end
        bus.in_valid = 1'b0;
        if (!taken) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL send_timeout: byte %0h not accepted, required in_ready within 20 cycles", b);
        end
    endtask

    typedef struct {
        int              n;
        logic [5:0][7:0] s;
        int              gap;
        logic            exp_done;
        logic            exp_err;
        logic [7:0]      exp_words;
        int              exp_writes;
    } vec_t;

    function automatic vec_t mk(input int n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] b4, input int gap,
                                input logic d, input logic e,
                                input logic [7:0] w, input int nw);
        vec_t v;
        v.n = n;
        v.s = '0;
        v.s[0] = b0; v.s[1] = b1; v.s[2] = b2; v.s[3] = b3; v.s[4] = b4;
        v.gap = gap;
        v.exp_done = d;
        v.exp_err = e;
        v.exp_words = w;
        v.exp_writes = nw;
        return v;
    endfunction

    vec_t vt [6];

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic c_CSUM = 1'b1;
`else
    localparam logic c_CSUM = 1'b0;
`endif

    initial begin
        logic last_hold;
        logic [7:0] sum32;

        // ------------------------------------------------------------
        // Vector table
        // ------------------------------------------------------------
`ifdef PROG_LOADER_CHECKSUM_EN
        vt[0] = mk(5, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 1'b1, 1'b0, 8'd3, 3);
        vt[1] = mk(1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'd0, 0);
        vt[2] = mk(2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'd0, 0);
        vt[3] = mk(4, 8'h02, 8'h11, 8'h22, 8'h33, 8'h00, 2, 1'b1, 1'b0, 8'd2, 2);
        vt[4] = mk(4, 8'h02, 8'h0F, 8'hF0, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 8'd2, 2);
        vt[5] = mk(4, 8'h02, 8'h0F, 8'hF0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'd2, 2);
`else
        vt[0] = mk(4, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 0, 1'b1, 1'b0, 8'd3, 3);
        vt[1] = mk(1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'd0, 0);
        vt[2] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'd0, 0);
        vt[3] = mk(3, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 2, 1'b1, 1'b0, 8'd2, 2);
        vt[4] = mk(2, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'd1, 1);
        vt[5] = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 8'd0, 0);
`endif

        bus.start    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // ------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------
        rst = 1'b1;
        tick(3);
        chk("rst_in_ready",  32'(bus.in_ready),     32'h0);
        chk("rst_mem_we",    32'(bus.mem_we),       32'h0);
        chk("rst_mem_addr",  32'(bus.mem_addr),     32'h00);
        chk("rst_mem_data",  32'(bus.mem_data),     32'h00);
        chk("rst_cpu_hold",  32'(bus.cpu_hold),     32'h1);
        chk("rst_load_done", 32'(bus.load_done),    32'h0);
        chk("rst_load_err",  32'(bus.load_err),     32'h0);
        chk("rst_words",     32'(bus.words_loaded), 32'h0);
        rst = 1'b0;
        tick(1);

        // ------------------------------------------------------------
        // in_valid in IDLE is not consumed
        // ------------------------------------------------------------
        clear_log();
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        tick(3);
        chk("idle_in_ready", 32'(bus.in_ready), 32'h0);
        chk("idle_hold",     32'(bus.cpu_hold), 32'h1);
        bus.in_valid = 1'b0;
        tick(1);
        chk("idle_writes", 32'(q_addr.size()), 32'd0);

        // ------------------------------------------------------------
        // Table-driven images
        // ------------------------------------------------------------
        for (int v = 0; v < 6; v++) begin
            clear_log();
            pulse_start();
            for (int b = 0; b < vt[v].n; b++) begin
                send_byte(vt[v].s[b]);
                if (b != vt[v].n - 1) tick(vt[v].gap);
            end
            tick(3);
            chk($sformatf("v%0d_done", v),     32'(bus.load_done),    32'(vt[v].exp_done));
            chk($sformatf("v%0d_err", v),      32'(bus.load_err),     32'(vt[v].exp_err));
            chk($sformatf("v%0d_hold", v),     32'(bus.cpu_hold),     32'(!vt[v].exp_done));
            chk($sformatf("v%0d_in_ready", v), 32'(bus.in_ready),     32'h0);
            chk($sformatf("v%0d_words", v),    32'(bus.words_loaded), 32'(vt[v].exp_words));
            chk($sformatf("v%0d_nwrites", v),  32'(q_addr.size()),    32'(vt[v].exp_writes));
            if (q_addr.size() == vt[v].exp_writes) begin
                for (int i = 0; i < vt[v].exp_writes; i++) begin
                    chk($sformatf("v%0d_addr%0d", v, i), 32'(q_addr[i]), 32'(i));
                    chk($sformatf("v%0d_data%0d", v, i), 32'(q_data[i]), 32'(vt[v].s[i+1]));
                    if (vt[v].gap == 0)
                        chk($sformatf("v%0d_back2back%0d", v, i), 32'(q_cyc[i]), 32'(q_cyc[0] + i));
                end
                if (vt[v].exp_writes > 0) begin
                    // Without a checksum stage the last write lands in DONE.
                    last_hold = c_CSUM ? 1'b1 : !vt[v].exp_done;
                    chk($sformatf("v%0d_last_hold", v),
                        32'(q_hold[vt[v].exp_writes-1]), 32'(last_hold));
                    chk($sformatf("v%0d_last_done", v),
                        32'(q_done[vt[v].exp_writes-1]), 32'(!last_hold));
                end
            end
        end

        // ------------------------------------------------------------
        // start pulse during DATA is ignored
        // ------------------------------------------------------------
        clear_log();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h44);
        pulse_start();
        send_byte(8'h55);
        if (c_CSUM) send_byte(8'h11);
        tick(3);
        chk("sd_done",    32'(bus.load_done),    32'h1);
        chk("sd_words",   32'(bus.words_loaded), 32'd2);
        chk("sd_nwrites", 32'(q_addr.size()),    32'd2);
        if (q_addr.size() == 2) begin
            chk("sd_addr1", 32'(q_addr[1]), 32'h01);
            chk("sd_data1", 32'(q_data[1]), 32'h55);
        end

        // ------------------------------------------------------------
        // Reset after 2nd of 4 data bytes, then a fresh load
        // ------------------------------------------------------------
        clear_log();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h10);
        send_byte(8'h20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mr_in_ready", 32'(bus.in_ready),     32'h0);
        chk("mr_hold",     32'(bus.cpu_hold),     32'h1);
        chk("mr_mem_we",   32'(bus.mem_we),       32'h0);
        chk("mr_words",    32'(bus.words_loaded), 32'h0);
        bus.in_data  = 8'h30;
        bus.in_valid = 1'b1;
        tick(4);
        bus.in_valid = 1'b0;
        chk("mr_nwrites",  32'(q_addr.size()),    32'd2);
        chk("mr_hold2",    32'(bus.cpu_hold),     32'h1);
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h77);
        if (c_CSUM) send_byte(8'h77);
        tick(3);
        chk("mr_reload_done",    32'(bus.load_done), 32'h1);
        chk("mr_reload_nwrites", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            chk("mr_reload_addr", 32'(q_addr[0]), 32'h00);
            chk("mr_reload_data", 32'(q_data[0]), 32'h77);
        end

        // ------------------------------------------------------------
        // Length exactly DEPTH is accepted
        // ------------------------------------------------------------
        clear_log();
        pulse_start();
        send_byte(8'd32);
        sum32 = 8'h00;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(i));
            sum32 = sum32 ^ 8'(i);
        end
        if (c_CSUM) send_byte(sum32);
        tick(3);
        chk("full_done",    32'(bus.load_done),    32'h1);
        chk("full_words",   32'(bus.words_loaded), 32'd32);
        chk("full_nwrites", 32'(q_addr.size()),    32'd32);
        if (q_addr.size() == 32) begin
            chk("full_last_addr", 32'(q_addr[31]), 32'h1F);
            chk("full_last_data", 32'(q_data[31]), 32'h1F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
